mbu_banked: RTL and testbench

//  Parametrised Memory Bank Unit: NREGS bank registers of AW bits that drive the extended address bus (AEXT).

---
 rtl/mbu_pkg.sv | 17 +
 rtl/mbu_regfile.sv | 56 +++++
 rtl/mbu_banked.sv | 123 ++++++++++++
 tb/tb_mbu_banked.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbu_pkg.sv
// Shared constants and types for the memory bank unit.
package mbu_pkg;

  localparam logic [7:0]  IOBASE_DEF = 8'h08;
  localparam int unsigned MBP        = 0;
  localparam int unsigned MBD        = 1;
  localparam int unsigned MBS        = 2;

  typedef enum logic [1:0] {SRC_MBP, SRC_WAR, SRC_IO, SRC_DEF} sel_src_t;
  typedef enum logic {ST_DISABLED, ST_ENABLED} mbu_state_t;

  // CTRL register sits directly above the bank register window
  function automatic logic [7:0] ctrl_addr(input logic [7:0] base, input int unsigned nregs);
    return 8'(32'(base) + nregs);
  endfunction

endpackage

// File: rtl/mbu_regfile.sv
// Bank register file: prioritised writes, auto-increment, two combinational
// read ports and a shadow copy of the low registers for context switches.
module mbu_regfile import mbu_pkg::*; #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned SHADOW = 4,
  parameter int unsigned IW     = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_mbp_en,
  input  logic [AW-1:0] wr_mbp_data,
  input  logic          io_wr_en,
  input  logic [IW-1:0] io_wr_idx,
  input  logic [AW-1:0] io_wr_data,
  input  logic          inc_en,
  input  logic [IW-1:0] inc_idx,
  input  logic          save,
  input  logic          restore,
  input  logic [IW-1:0] rd_idx_a,
  output logic [AW-1:0] rd_data_a,
  input  logic [IW-1:0] rd_idx_b,
  output logic [AW-1:0] rd_data_b
);

  logic [AW-1:0] regs     [NREGS];
  logic [AW-1:0] regs_nxt [NREGS];
  logic [AW-1:0] shadow   [SHADOW];

  assign rd_data_a = regs[rd_idx_a];
  assign rd_data_b = regs[rd_idx_b];

  // Later assignments override earlier ones: restore > CU > I/O > increment
  always_comb begin
    regs_nxt = regs;
    if (inc_en)    regs_nxt[inc_idx]   = regs[inc_idx] + AW'(1);
    if (io_wr_en)  regs_nxt[io_wr_idx] = io_wr_data;
    if (wr_mbp_en) regs_nxt[MBP]       = wr_mbp_data;
    if (restore) begin
      for (int i = 0; i < int'(SHADOW); i++) regs_nxt[i] = shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
      for (int i = 0; i < int'(SHADOW); i++) shadow[i] <= '0;
    end else begin
      regs <= regs_nxt;
      if (save) begin
        for (int i = 0; i < int'(SHADOW); i++) shadow[i] <= regs[i];
      end
    end
  end

endmodule

// File: rtl/mbu_banked.sv
// Memory bank unit: enable FSM, index-pending flag, read-select mux and
// registered I/O read path around the bank register file.
module mbu_banked import mbu_pkg::*; #(
  parameter int unsigned NREGS  = 8,
  parameter int unsigned AW     = 8,
  parameter int unsigned SHADOW = 4,
  parameter logic [7:0]  IOBASE = IOBASE_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fpram_rom_n,
  input  logic                     io_wr,
  input  logic                     io_rd,
  input  logic [7:0]               io_addr,
  input  logic [AW-1:0]            io_wdata,
  output logic [AW-1:0]            io_rdata,
  output logic                     io_rvalid,
  input  logic                     cu_wr_mbp,
  input  logic                     cu_rd_mbp,
  input  logic [AW-1:0]            ibus_wdata,
  output logic [AW-1:0]            ibus_rdata,
  input  logic                     war,
  input  logic [1:0]               waddr_idx,
  input  logic                     ir_idx_req,
  input  logic [$clog2(NREGS)-1:0] ir,
  input  logic                     ar_carry,
  input  logic                     ctx_save,
  input  logic                     ctx_restore,
  output logic [AW-1:0]            aext,
  output logic                     enabled
);

  localparam int unsigned IW        = $clog2(NREGS);
  localparam logic [7:0]  CTRL_ADDR = ctrl_addr(IOBASE, NREGS);

  mbu_state_t     state;
  logic           idx_pend;
  logic [NREGS-1:0] ctrl;
  logic [7:0]     io_ofs;
  logic           io_is_reg;
  logic           io_is_ctrl;
  sel_src_t       src;
  logic [IW-1:0]  war_idx;
  logic [IW-1:0]  sel;
  logic [AW-1:0]  rd_a;
  logic [AW-1:0]  rd_b;
  logic [AW-1:0]  dis_val;
  logic           inc_en;

  assign io_ofs     = io_addr - IOBASE;
  assign io_is_reg  = (io_addr >= IOBASE) && (io_ofs < 8'(NREGS));
  assign io_is_ctrl = (io_addr == CTRL_ADDR);
  assign war_idx    = (idx_pend && waddr_idx == 2'd3) ? ir : IW'(waddr_idx);
  assign dis_val    = {fpram_rom_n, {(AW-1){1'b0}}};
  assign enabled    = (state == ST_ENABLED);

  // Read-select priority: CU MBP read, AR indexing, I/O read, default MBP
  always_comb begin
    src = SRC_DEF;
    sel = IW'(MBP);
    if (cu_rd_mbp)              src = SRC_MBP;
    else if (war)               src = SRC_WAR;
    else if (io_rd && io_is_reg) src = SRC_IO;
    case (src)
      SRC_WAR: sel = war_idx;
      SRC_IO:  sel = io_ofs[IW-1:0];
      default: sel = IW'(MBP);
    endcase
  end

  assign aext       = enabled ? rd_a : dis_val;
  assign ibus_rdata = cu_rd_mbp ? aext : '0;
  assign inc_en     = war && ar_carry && enabled && ctrl[sel];

  mbu_regfile #(
    .NREGS  (NREGS),
    .AW     (AW),
    .SHADOW (SHADOW),
    .IW     (IW)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .wr_mbp_en   (cu_wr_mbp),
    .wr_mbp_data (ibus_wdata),
    .io_wr_en    (io_wr && io_is_reg),
    .io_wr_idx   (io_ofs[IW-1:0]),
    .io_wr_data  (io_wdata),
    .inc_en      (inc_en),
    .inc_idx     (sel),
    .save        (ctx_save),
    .restore     (ctx_restore),
    .rd_idx_a    (sel),
    .rd_data_a   (rd_a),
    .rd_idx_b    (io_ofs[IW-1:0]),
    .rd_data_b   (rd_b)
  );

  // Enable FSM, index-pending flag, CTRL mask and I/O read register
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_DISABLED;
      idx_pend  <= 1'b0;
      ctrl      <= '0;
      io_rvalid <= 1'b0;
      io_rdata  <= '0;
    end else begin
      case (state)
        ST_DISABLED: if (io_wr && io_is_reg) state <= ST_ENABLED;
        default:     state <= ST_ENABLED;
      endcase
      if (ir_idx_req)  idx_pend <= 1'b1;
      else if (war)    idx_pend <= 1'b0;
      if (io_wr && io_is_ctrl) ctrl <= NREGS'(io_wdata);
      io_rvalid <= io_rd;
      if (io_rd) begin
        if (io_is_reg)       io_rdata <= enabled ? rd_b : dis_val;
        else if (io_is_ctrl) io_rdata <= AW'(ctrl);
        else                 io_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mbu_banked.sv
// Directed and randomized checks of mbu_banked against a behavioural model.
module tb_mbu_banked;

  logic       clk;
  logic       reset;
  logic       fpram_rom_n;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_rvalid;
  logic       cu_wr_mbp;
  logic       cu_rd_mbp;
  logic [7:0] ibus_wdata;
  logic [7:0] ibus_rdata;
  logic       war;
  logic [1:0] waddr_idx;
  logic       ir_idx_req;
  logic [2:0] ir;
  logic       ar_carry;
  logic       ctx_save;
  logic       ctx_restore;
  logic [7:0] aext;
  logic       enabled;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  logic [7:0] m_regs [8];
  logic [7:0] m_shadow [4];
  logic [7:0] m_ctrl;
  logic       m_en;
  logic       m_pend;
  logic       m_rvalid;
  logic [7:0] m_rdata;

  mbu_banked dut (
    .clk         (clk),
    .reset       (reset),
    .fpram_rom_n (fpram_rom_n),
    .io_wr       (io_wr),
    .io_rd       (io_rd),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_rvalid   (io_rvalid),
    .cu_wr_mbp   (cu_wr_mbp),
    .cu_rd_mbp   (cu_rd_mbp),
    .ibus_wdata  (ibus_wdata),
    .ibus_rdata  (ibus_rdata),
    .war         (war),
    .waddr_idx   (waddr_idx),
    .ir_idx_req  (ir_idx_req),
    .ir          (ir),
    .ar_carry    (ar_carry),
    .ctx_save    (ctx_save),
    .ctx_restore (ctx_restore),
    .aext        (aext),
    .enabled     (enabled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_regs(input logic [7:0] a);
    return (a >= 8'h08) && (a <= 8'h0F);
  endfunction

  function automatic int m_sel();
    if (cu_rd_mbp) return 0;
    if (war) return (m_pend && waddr_idx == 2'd3) ? int'(ir) : int'(waddr_idx);
    if (io_rd && in_regs(io_addr)) return int'(io_addr) - 8;
    return 0;
  endfunction

  function automatic logic [7:0] m_aext();
    if (!m_en) return {fpram_rom_n, 7'b0};
    return m_regs[m_sel()];
  endfunction

  task automatic model_step();
    logic [7:0] nr [8];
    logic [7:0] ns [4];
    int s;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      for (int i = 0; i < 4; i++) m_shadow[i] = 8'h00;
      m_ctrl = 8'h00; m_en = 1'b0; m_pend = 1'b0; m_rvalid = 1'b0; m_rdata = 8'h00;
      return;
    end
    nr = m_regs;
    ns = m_shadow;
    s  = m_sel();
    m_rvalid = io_rd;
    if (io_rd) begin
      if (in_regs(io_addr)) m_rdata = m_en ? m_regs[int'(io_addr) - 8] : {fpram_rom_n, 7'b0};
      else if (io_addr == 8'h10) m_rdata = m_ctrl;
      else m_rdata = 8'h00;
    end
    if (war && ar_carry && m_en && m_ctrl[s]) nr[s] = m_regs[s] + 8'd1;
    if (io_wr && in_regs(io_addr)) nr[int'(io_addr) - 8] = io_wdata;
    if (cu_wr_mbp) nr[0] = ibus_wdata;
    if (ctx_restore) for (int i = 0; i < 4; i++) nr[i] = m_shadow[i];
    if (ctx_save) for (int i = 0; i < 4; i++) ns[i] = m_regs[i];
    if (io_wr && io_addr == 8'h10) m_ctrl = io_wdata;
    if (io_wr && in_regs(io_addr)) m_en = 1'b1;
    if (ir_idx_req) m_pend = 1'b1;
    else if (war) m_pend = 1'b0;
    m_regs = nr;
    m_shadow = ns;
  endtask

  task automatic idle();
    reset = 0; io_wr = 0; io_rd = 0; io_addr = 0; io_wdata = 0;
    cu_wr_mbp = 0; cu_rd_mbp = 0; ibus_wdata = 0; war = 0; waddr_idx = 0;
    ir_idx_req = 0; ir = 0; ar_carry = 0; ctx_save = 0; ctx_restore = 0;
  endtask

  // One clock: combinational outputs mid-cycle, registered outputs after the edge
  task automatic cycle();
    @(negedge clk);
    check("aext", 32'(aext), 32'(m_aext()));
    check("ibus_rdata", 32'(ibus_rdata), cu_rd_mbp ? 32'(m_aext()) : 32'h0);
    @(posedge clk);
    model_step();
    #1;
    check("io_rvalid", 32'(io_rvalid), 32'(m_rvalid));
    check("io_rdata", 32'(io_rdata), 32'(m_rdata));
    check("enabled", 32'(enabled), 32'(m_en));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    idle(); io_wr = 1; io_addr = a; io_wdata = d;
    cycle(); idle();
  endtask

  task automatic peek(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    war = 1; waddr_idx = idx;
    #1 check(tag, 32'(aext), 32'(exp));
    cycle(); war = 0;
  endtask

  initial begin
    idle(); reset = 1; fpram_rom_n = 1;
    cycle(); cycle();
    reset = 0; cycle();
    #1 check("rst_aext_rom", 32'(aext), 32'h80);
    check("rst_enabled", 32'(enabled), 32'h0);
    fpram_rom_n = 0;
    #1 check("rst_aext_ram", 32'(aext), 32'h00);
    cycle();

    wr(8'h0A, 8'h3C);
    check("enable_on_wr", 32'(enabled), 32'h1);
    peek("war_reg2", 2'd2, 8'h3C);
    io_rd = 1; io_addr = 8'h0A; cycle(); idle();
    check("io_rd_valid", 32'(io_rvalid), 32'h1);
    check("io_rd_data", 32'(io_rdata), 32'h3C);
    cycle();
    check("io_rvalid_pulse", 32'(io_rvalid), 32'h0);

    wr(8'h0D, 8'h77); wr(8'h0B, 8'h33);
    ir_idx_req = 1; cycle(); idle();
    ir = 3'd5; peek("ir_index", 2'd3, 8'h77);
    ir = 3'd5; peek("pend_cleared", 2'd3, 8'h33);

    wr(8'h10, 8'h02); wr(8'h09, 8'hFF);
    war = 1; waddr_idx = 2'd1; ar_carry = 1; cycle(); idle();
    peek("autoinc_wrap", 2'd1, 8'h00);
    war = 1; waddr_idx = 2'd1; ar_carry = 1; io_wr = 1; io_addr = 8'h09; io_wdata = 8'h10;
    cycle(); idle();
    peek("inc_suppressed", 2'd1, 8'h10);
    war = 1; waddr_idx = 2'd2; ar_carry = 1; cycle(); idle();
    peek("inc_masked", 2'd2, 8'h3C);

    for (int i = 0; i < 4; i++) wr(8'(8 + i), 8'(i + 1));
    ctx_save = 1; cycle(); idle();
    for (int i = 0; i < 4; i++) wr(8'(8 + i), 8'h09);
    ctx_restore = 1; cycle(); idle();
    for (int i = 0; i < 4; i++) peek("restore", 2'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) wr(8'(8 + i), 8'h09);
    ctx_save = 1; ctx_restore = 1; cycle(); idle();
    peek("swap_regs", 2'd3, 8'h04);
    ctx_restore = 1; cycle(); idle();
    peek("swap_shadow", 2'd3, 8'h09);

    cu_wr_mbp = 1; ibus_wdata = 8'h11; io_wr = 1; io_addr = 8'h08; io_wdata = 8'h22;
    cycle(); idle();
    cu_rd_mbp = 1;
    #1 check("cu_over_io", 32'(ibus_rdata), 32'h11);
    cycle(); idle();

    io_rd = 1; io_addr = 8'h20; cycle(); idle();
    check("io_rd_oor_valid", 32'(io_rvalid), 32'h1);
    check("io_rd_oor_data", 32'(io_rdata), 32'h0);

    io_rd = 1; io_addr = 8'h0A; reset = 1; cycle(); idle();
    check("rst_drops_rvalid", 32'(io_rvalid), 32'h0);
    cycle();
    check("rst_rvalid_next", 32'(io_rvalid), 32'h0);
    check("rst_disables", 32'(enabled), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      fpram_rom_n = 1'($urandom);
      io_wr       = ($urandom_range(0, 3) == 0);
      io_rd       = ($urandom_range(0, 2) == 0);
      io_addr     = 8'($urandom_range(5, 18));
      io_wdata    = 8'($urandom);
      cu_wr_mbp   = ($urandom_range(0, 7) == 0);
      cu_rd_mbp   = ($urandom_range(0, 5) == 0);
      ibus_wdata  = 8'($urandom);
      war         = ($urandom_range(0, 2) == 0);
      waddr_idx   = 2'($urandom);
      ir_idx_req  = ($urandom_range(0, 5) == 0);
      ir          = 3'($urandom);
      ar_carry    = 1'($urandom);
      ctx_save    = ($urandom_range(0, 9) == 0);
      ctx_restore = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
